// File: rtl/bmove_arbiter_pkg.sv
// Shared othello definitions: arbiter FSM encoding, requester indices and the
// operand bundle handed to the single b_move instance.
package bmove_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int REQ_GLUE = 0;  // glue FSM: human move / commit
  localparam int REQ_AI   = 1;  // game_ai search

  typedef struct packed {
    logic [63:0] r;
    logic [63:0] b;
    logic [2:0]  x;
    logic [2:0]  y;
    logic        pl;
  } operand_t;

endpackage

// File: rtl/bmove_arbiter.sv
// Two-port round-robin arbiter sharing one b_move instance between the glue FSM
// and the AI search; pass requests bypass b_move and return the input boards.
module bmove_arbiter
  import bmove_arbiter_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        req0,
  input  logic        req1,
  input  logic [63:0] r0_R,
  input  logic [63:0] r0_B,
  input  logic [63:0] r1_R,
  input  logic [63:0] r1_B,
  input  logic [2:0]  r0_x,
  input  logic [2:0]  r0_y,
  input  logic [2:0]  r1_x,
  input  logic [2:0]  r1_y,
  input  logic        r0_pl,
  input  logic        r1_pl,
  input  logic        r0_pass,
  input  logic        r1_pass,
  output logic [63:0] bm_R,
  output logic [63:0] bm_B,
  output logic [2:0]  bm_x,
  output logic [2:0]  bm_y,
  output logic        bm_player,
  input  logic [63:0] bm_R_OUT,
  input  logic [63:0] bm_B_OUT,
  output logic [63:0] res_R,
  output logic [63:0] res_B,
  output logic        done0,
  output logic        done1,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam logic [2:0] CNT_LAST = 3'(LATENCY - 1);

  arb_state_t  r_state;
  arb_state_t  w_next;
  operand_t    r_op;
  operand_t    w_op;
  logic [2:0]  r_cnt;
  logic        r_owner;
  logic        r_last;
  logic [63:0] r_res_r;
  logic [63:0] r_res_b;
  logic        w_any;
  logic        w_pick;
  logic        w_pass;
  logic        w_grant_now;

  // Round-robin pick: a lone request always wins, a tie goes to the port not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_any  = req0 | req1;
    w_pick = (req0 && req1) ? ~r_last : req1;
    w_op   = '{r: r0_R, b: r0_B, x: r0_x, y: r0_y, pl: r0_pl};
    w_pass = r0_pass;
    if (w_pick) begin
      w_op   = '{r: r1_R, b: r1_B, x: r1_x, y: r1_y, pl: r1_pl};
      w_pass = r1_pass;
    end
  end

  assign w_grant_now = (r_state == ST_IDLE) && w_any;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any) w_next = w_pass ? ST_DONE : ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (r_cnt == CNT_LAST) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Operand latch, wait counter and result capture.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_op    <= '0;
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'(REQ_AI);
      r_res_r <= '0;
      r_res_b <= '0;
    end else begin
      if (w_grant_now) begin
        r_owner <= w_pick;
        r_last  <= w_pick;
        // A pass never touches b_move, so its boards go straight to the result.
        if (w_pass) begin
          r_res_r <= w_op.r;
          r_res_b <= w_op.b;
        end else begin
          r_op <= w_op;
        end
      end
      if (r_state == ST_ISSUE)     r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + 3'd1;
      if (r_state == ST_WAIT && r_cnt == CNT_LAST) begin
        r_res_r <= bm_R_OUT;
        r_res_b <= bm_B_OUT;
      end
    end
  end

  // Outputs decoded from state and owner.
  always_comb begin
    busy  = (r_state != ST_IDLE);
    grant = 2'b00;
    if (r_state != ST_IDLE) grant = r_owner ? 2'b10 : 2'b01;
    done0 = (r_state == ST_DONE) && (r_owner == 1'(REQ_GLUE));
    done1 = (r_state == ST_DONE) && (r_owner == 1'(REQ_AI));
  end

  assign bm_R      = r_op.r;
  assign bm_B      = r_op.b;
  assign bm_x      = r_op.x;
  assign bm_y      = r_op.y;
  assign bm_player = r_op.pl;
  assign res_R     = r_res_r;
  assign res_B     = r_res_b;

endmodule

// File: doc/bmove_arbiter.md
BMOVE_ARBITER -- requirements
Module: bmove_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, cycles from b_move input change to valid R_OUT/B_OUT (legal range 1..7).
REQ-002 Port clk, input, 1, global clock; all state changes on rising edge.
REQ-003 Port RST, input, 1, reset; one clock, reset synchronous and active-high.
REQ-004 Ports req0/req1, input, 1 each, move request; requester 0 = glue FSM (human/commit), requester 1 = game_ai search.
REQ-005 Ports r0_R/r0_B and r1_R/r1_B, input, 64 each, red/blue board operands per requester.
REQ-006 Ports r0_x/r0_y and r1_x/r1_y, input, 3 each, move coordinates.
REQ-007 Ports r0_pl/r1_pl, input, 1 each, player to move.
REQ-008 Ports r0_pass/r1_pass, input, 1 each, pass request: result equals input boards and b_move is not used.
REQ-009 Ports bm_R/bm_B (64), bm_x/bm_y (3), bm_player (1), output, drive the shared b_move instance.
REQ-010 Ports bm_R_OUT/bm_B_OUT, input, 64 each, b_move results.
REQ-011 Ports res_R/res_B, output, 64 each, result boards, shared by both requesters.
REQ-012 Port done0/done1, output, 1 each, one-cycle result-valid pulse to the owning requester.
REQ-013 Port grant, output, 2, one-hot current owner; 00 when idle.
REQ-014 Port busy, output, 1, high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: no request -> IDLE.
- IDLE: request granted -> ISSUE.
- ISSUE -> WAIT.
- WAIT: counter = LATENCY-1 -> DONE.
- DONE -> IDLE.
REQ-016 In IDLE, the arbiter latches the granted requester's R, B, x, y, pl and pass into operand registers on the grant edge; later changes on requester inputs have no effect on that operation.
REQ-017 Arbitration is round-robin when both requests are high in IDLE: grant the port not served last. The last-served flag resets so that port 0 wins the first tie.
REQ-018 A single active request is granted immediately, regardless of the last-served flag.
REQ-019 bm_* outputs come from the operand registers and stay stable from ISSUE through DONE. In IDLE they hold their previous value.
REQ-020 WAIT counter: 3 bits, cleared on entry to WAIT, increments each WAIT cycle, no wrap within an operation.
REQ-021 Non-pass operation: on the WAIT->DONE edge, res_R/res_B capture bm_R_OUT/bm_B_OUT.
- done of the owner is high for exactly the DONE cycle.
- Request sampled in IDLE at edge k gives done high in cycle k+LATENCY+2.
REQ-022 Pass operation goes IDLE -> DONE directly.
- res_R/res_B = latched operand boards.
- done is high in cycle k+1.
- b_move outputs are ignored.
REQ-023 res_R/res_B hold their value until the next capture.
REQ-024 The requester holds req until done. Dropping req mid-operation does not abort: the operation completes and done still pulses.
REQ-025 req still high in the cycle after DONE counts as a new request. Consequence: back-to-back service from one port costs one IDLE cycle between operations.
REQ-026 done0 and done1 are never high in the same cycle.
REQ-027 grant is set from the grant edge until the DONE->IDLE edge.

Reset
REQ-028 Every output resets to 0 on RST=1 at a clock edge (res_R, res_B, bm_* all zero). Values after reset:
- state = IDLE
- counter = 0
- operand registers = 0
- last-served = port 1
REQ-029 RST asserted mid-operation abandons the operation. No done pulse is issued, and the first request after RST deasserts is arbitrated fresh.

Structure
REQ-030 The FSM state encodings and the requester indices (REQ_GLUE=0, REQ_AI=1) live in a shared othello package.
REQ-031 The arbiter contains no sub-module; b_move stays instantiated beside it in the top level. The round-robin picker is inline logic, not a separate module.

Verification
REQ-032 Scenario: req0 alone, opening board, x=2 y=3 pl=0, LATENCY=2.
- bm_* driven with those operands.
- done0 pulses once, 4 cycles after the req sample.
- res equals the b_move output.
REQ-033 Scenario: req0 and req1 rise in the same cycle after reset.
- Port 0 is served first, then port 1.
- grant sequence: 01, 00, 10.
- done0 precedes done1.
REQ-034 Scenario: req1 with pass=1 and arbitrary boards.
- done1 high at k+1.
- res equals the input boards.
- bm_* unchanged.
REQ-035 Scenario: req0 drops in WAIT and its operands change during WAIT.
- bm_* stay stable.
- done0 still pulses.
- res reflects the originally latched move.
REQ-036 Scenario: RST pulsed during WAIT of a req1 operation.
- Outputs go to zero and no done1 pulse is issued.
- A following req1 is served normally.
REQ-037 Scenario: req1 held continuously for 3 operations while req0 is idle.
- Three done1 pulses, each separated by exactly LATENCY+3 cycles.
